// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared slot record, forward-select constant and slot helper
//               for the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int c_DST_W_MAX = 8;
    localparam int FWD_RF      = 0;

    typedef struct packed {
        logic                   valid;
        logic [c_DST_W_MAX-1:0] dst;
        logic                   regwrite;
        logic                   is_load;
        logic                   pcwrite;
    } slot_t;

    // A writer seen in slot k while the consumer is in D sits in slot k+1 once the consumer reaches E.
    function automatic int sel_of(input int k);
        return k + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_slot_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hazard_slot_pipe
// Description : Shift register of in-flight writers, E at index 0, W last.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_slot_pipe
    import hazard_pkg::*;
#(
    parameter int NSLOT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load_e,
    input  slot_t               i_slot,
    output slot_t [NSLOT-1:0]   o_slots
);

    slot_t [NSLOT-1:0] r_slots;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slots <= '0;
        end else begin
            r_slots[0] <= i_load_e ? i_slot : '0;
            for (int k = 1; k < NSLOT; k++) begin
                r_slots[k] <= r_slots[k-1];
            end
        end
    end

    assign o_slots = r_slots;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Forwarding select, load-use stall, branch/PC-write flush and
//               stall-cycle counter for a pipeline with MEM_STAGES memory stages.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int RA_W       = 4,
    parameter  int NSRC       = 3,
    parameter  int MEM_STAGES = 1,
    localparam int NSLOT      = MEM_STAGES + 2,
    localparam int SEL_W      = $clog2(NSLOT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   validD,
    input  logic [NSRC*RA_W-1:0]   srcD,
    input  logic [NSRC-1:0]        src_useD,
    input  logic [RA_W-1:0]        dstD,
    input  logic                   regwriteD,
    input  logic                   is_loadD,
    input  logic                   pcwriteD,
    input  logic                   branch_takenE,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   flushD,
    output logic                   flushE,
    output logic [NSRC*SEL_W-1:0]  fwd_selE,
    output logic [31:0]            stall_cnt
);

    slot_t [NSLOT-1:0]      w_slots;
    slot_t                  w_slot_d;
    logic [NSRC*SEL_W-1:0]  w_sel_d;
    logic [NSRC-1:0]        w_haz;
    logic                   w_ldstall;
    logic                   w_pcpend;
    logic                   w_pcw;
    logic                   w_load_e;
    logic [NSRC*SEL_W-1:0]  r_fwd_sel;
    logic [31:0]            r_stall_cnt;

    always_comb begin
        w_slot_d          = '0;
        w_slot_d.valid    = validD;
        w_slot_d.dst      = c_DST_W_MAX'(dstD);
        w_slot_d.regwrite = regwriteD;
        w_slot_d.is_load  = is_loadD;
        w_slot_d.pcwrite  = pcwriteD;
    end

    // Scan oldest to youngest so the youngest matching writer overrides.
    always_comb begin
        w_sel_d = '0;
        w_haz   = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = NSLOT - 1; k >= 0; k--) begin
                if (validD && src_useD[i] && w_slots[k].valid && w_slots[k].regwrite &&
                    (w_slots[k].dst == c_DST_W_MAX'(srcD[i*RA_W +: RA_W]))) begin
                    if (k == NSLOT - 1) begin
                        w_sel_d[i*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
                        w_haz[i]                  = 1'b0;
                    end else begin
                        w_sel_d[i*SEL_W +: SEL_W] = SEL_W'(sel_of(k));
                        w_haz[i]                  = w_slots[k].is_load && (sel_of(k) < NSLOT - 1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_pcpend = validD && pcwriteD;
        for (int k = 0; k < NSLOT - 1; k++) begin
            w_pcpend = w_pcpend || (w_slots[k].valid && w_slots[k].pcwrite);
        end
        w_pcw = w_slots[NSLOT-1].valid && w_slots[NSLOT-1].pcwrite;
    end

    assign w_ldstall = |w_haz;
    assign stallD    = w_ldstall && !branch_takenE;
    assign stallF    = stallD || w_pcpend;
    assign flushD    = branch_takenE || w_pcpend || w_pcw;
    assign flushE    = w_ldstall || branch_takenE;
    assign w_load_e  = !stallD && !flushE;

    hazard_slot_pipe #(
        .NSLOT (NSLOT)
    ) u_slot_pipe (
        .clk      (clk),
        .reset    (reset),
        .i_load_e (w_load_e),
        .i_slot   (w_slot_d),
        .o_slots  (w_slots)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fwd_sel   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_fwd_sel <= w_load_e ? w_sel_d : '0;
            if (stallD && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fwd_selE  = r_fwd_sel;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench; one instance with one memory
//               stage and one with two, fed from shared D-stage stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        validD;
    logic [11:0] srcD;
    logic [2:0]  src_useD;
    logic [3:0]  dstD;
    logic        regwriteD;
    logic        is_loadD;
    logic        pcwriteD;
    logic        branch_takenE;

    logic        stallF1, stallD1, flushD1, flushE1;
    logic [5:0]  fwd_selE1;
    logic [31:0] stall_cnt1;
    logic        stallF2, stallD2, flushD2, flushE2;
    logic [5:0]  fwd_selE2;
    logic [31:0] stall_cnt2;

    int n_checks;
    int n_errors;

    hazard_scoreboard #(.RA_W(4), .NSRC(3), .MEM_STAGES(1)) u_dut1 (
        .clk(clk), .reset(reset), .validD(validD), .srcD(srcD), .src_useD(src_useD),
        .dstD(dstD), .regwriteD(regwriteD), .is_loadD(is_loadD), .pcwriteD(pcwriteD),
        .branch_takenE(branch_takenE), .stallF(stallF1), .stallD(stallD1),
        .flushD(flushD1), .flushE(flushE1), .fwd_selE(fwd_selE1), .stall_cnt(stall_cnt1)
    );

    hazard_scoreboard #(.RA_W(4), .NSRC(3), .MEM_STAGES(2)) u_dut2 (
        .clk(clk), .reset(reset), .validD(validD), .srcD(srcD), .src_useD(src_useD),
        .dstD(dstD), .regwriteD(regwriteD), .is_loadD(is_loadD), .pcwriteD(pcwriteD),
        .branch_takenE(branch_takenE), .stallF(stallF2), .stallD(stallD2),
        .flushD(flushD2), .flushE(flushE2), .fwd_selE(fwd_selE2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_d(input logic v, input logic [11:0] s, input logic [2:0] u,
                           input logic [3:0] d, input logic rw, input logic ld, input logic pcw);
        validD    = v;
        srcD      = s;
        src_useD  = u;
        dstD      = d;
        regwriteD = rw;
        is_loadD  = ld;
        pcwriteD  = pcw;
    endtask

    task automatic idle_d();
        drive_d(1'b0, 12'h000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_d();
        branch_takenE = 1'b0;
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        branch_takenE = 1'b0;
        idle_d();
        next_cycle();
        next_cycle();
        reset = 1'b1;

        // Reset during a load stall (one memory stage)
        drive_d(1'b1, 12'h001, 3'b001, 4'd5, 1'b1, 1'b1, 1'b0);   // LDR r5
        next_cycle();
        drive_d(1'b1, 12'h005, 3'b001, 4'd6, 1'b1, 1'b0, 1'b0);   // ADD r6,r5
        @(negedge clk);
        check("t1_stall_before_reset", 32'(stallD1), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("t1_stallD_in_reset", 32'(stallD1), 32'd0);
        check("t1_stallF_in_reset", 32'(stallF1), 32'd0);
        check("t1_flushD_in_reset", 32'(flushD1), 32'd0);
        check("t1_flushE_in_reset", 32'(flushE1), 32'd0);
        check("t1_fwd_in_reset", 32'(fwd_selE1), 32'd0);
        check("t1_cnt_in_reset", stall_cnt1, 32'd0);
        next_cycle();
        reset = 1'b1;
        idle_d();
        next_cycle();
        check("t1_fwd_after_release", 32'(fwd_selE1), 32'd0);

        // ALU-use forwards from M1 with no stall
        do_reset();
        drive_d(1'b1, 12'h021, 3'b011, 4'd3, 1'b1, 1'b0, 1'b0);   // ADD r3,r1,r2
        next_cycle();
        drive_d(1'b1, 12'h003, 3'b001, 4'd4, 1'b1, 1'b0, 1'b0);   // SUB r4,r3
        @(negedge clk);
        check("t2_no_stall", 32'(stallD1), 32'd0);
        check("t2_no_flushE", 32'(flushE1), 32'd0);
        next_cycle();
        idle_d();
        check("t2_fwd_m1", 32'(fwd_selE1), 32'h01);

        // Load-use with two memory stages
        do_reset();
        drive_d(1'b1, 12'h001, 3'b001, 4'd5, 1'b1, 1'b1, 1'b0);   // LDR r5
        next_cycle();
        drive_d(1'b1, 12'h005, 3'b001, 4'd6, 1'b1, 1'b0, 1'b0);   // ADD r6,r5
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t3_stallD", 32'(stallD2), 32'd1);
            check("t3_stallF", 32'(stallF2), 32'd1);
            check("t3_flushE", 32'(flushE2), 32'd1);
            next_cycle();
            check("t3_fwd_bubble", 32'(fwd_selE2), 32'd0);
        end
        @(negedge clk);
        check("t3_stall_released", 32'(stallD2), 32'd0);
        next_cycle();
        idle_d();
        check("t3_fwd_w", 32'(fwd_selE2), 32'h03);
        check("t3_stall_cnt", stall_cnt2, 32'd2);

        // Youngest writer wins; an unused operand naming the same register gets 0
        do_reset();
        drive_d(1'b1, 12'h001, 3'b001, 4'd2, 1'b1, 1'b0, 1'b0);   // older writer of r2
        next_cycle();
        drive_d(1'b1, 12'h001, 3'b001, 4'd2, 1'b1, 1'b0, 1'b0);   // younger writer of r2
        next_cycle();
        idle_d();
        next_cycle();
        drive_d(1'b1, 12'h022, 3'b001, 4'd7, 1'b1, 1'b0, 1'b0);   // reads r2 on op0, op1 unused
        @(negedge clk);
        check("t4_no_stall", 32'(stallD1), 32'd0);
        next_cycle();
        idle_d();
        check("t4_fwd_youngest", 32'(fwd_selE1), 32'h02);

        // Unused operand naming a fresh load never stalls
        do_reset();
        drive_d(1'b1, 12'h001, 3'b001, 4'd7, 1'b1, 1'b1, 1'b0);   // LDR r7
        next_cycle();
        drive_d(1'b1, 12'h071, 3'b001, 4'd8, 1'b1, 1'b0, 1'b0);   // op1=r7 unused
        @(negedge clk);
        check("t4b_unused_no_stall", 32'(stallD2), 32'd0);
        check("t4b_unused_no_flushE", 32'(flushE2), 32'd0);

        // Taken branch overrides a load stall
        do_reset();
        drive_d(1'b1, 12'h001, 3'b001, 4'd5, 1'b1, 1'b1, 1'b0);   // LDR r5
        next_cycle();
        drive_d(1'b1, 12'h005, 3'b001, 4'd6, 1'b1, 1'b0, 1'b0);   // ADD r6,r5
        branch_takenE = 1'b1;
        @(negedge clk);
        check("t5_stallD", 32'(stallD1), 32'd0);
        check("t5_stallF", 32'(stallF1), 32'd0);
        check("t5_flushD", 32'(flushD1), 32'd1);
        check("t5_flushE", 32'(flushE1), 32'd1);
        next_cycle();
        branch_takenE = 1'b0;
        drive_d(1'b1, 12'h006, 3'b001, 4'd7, 1'b1, 1'b0, 1'b0);   // SUB r7,r6
        check("t5_fwd_bubble", 32'(fwd_selE1), 32'd0);
        next_cycle();
        idle_d();
        check("t5_discarded_add", 32'(fwd_selE1), 32'd0);
        check("t5_cnt", stall_cnt1, 32'd0);

        // PC write holds fetch for three cycles and flushes D for four
        do_reset();
        drive_d(1'b1, 12'h001, 3'b001, 4'd15, 1'b1, 1'b0, 1'b1);  // MOV pc,r1
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t6_stallF_c%0d", c), 32'(stallF1), (c < 3) ? 32'd1 : 32'd0);
            check($sformatf("t6_flushD_c%0d", c), 32'(flushD1), (c < 4) ? 32'd1 : 32'd0);
            next_cycle();
            idle_d();
        end
        check("t6_cnt", stall_cnt1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
